// File: rtl/gcd_pkg.sv
// gcd_pkg
// Shared definitions for the binary (Stein) GCD engine:
//   state_e        - controller state encoding (3 bits)
//   gcd_lat_bound  - upper bound on start-to-done latency in cycles
package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    STRIP = 3'd2,
    ODDX  = 3'd3,
    LOOP  = 3'd4,
    DONE  = 3'd5
  } state_e;

  // Worst-case number of cycles from an accepted start to the done pulse.
  function automatic int unsigned gcd_lat_bound(input int unsigned width);
    return 4 * width + 4;
  endfunction

endpackage

// File: rtl/gcd_binary_if.sv
// gcd_binary_if
// Start/done request bundle between a controller (master) and the GCD
// engine (slave).
//   start    master->slave  request, sampled by the engine only when idle
//   a, b     master->slave  operands, captured together with start
//   outp     slave->master  result, valid with done and held afterwards
//   done     slave->master  one-cycle result-valid pulse
//   busy     slave->master  operation in progress
//   zero_in  slave->master  at least one operand was zero (held with outp)
interface gcd_binary_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] outp;
  logic             done;
  logic             busy;
  logic             zero_in;

  modport master (
    output start, a, b,
    input  outp, done, busy, zero_in
  );

  modport slave (
    input  start, a, b,
    output outp, done, busy, zero_in
  );

endinterface

// File: rtl/gcd_binary_step.sv
// gcd_binary_step
// Combinational datapath for one iteration of the odd-x reduction loop.
//   x_i, y_i  current operands (x_i is odd whenever this result is used)
//   x_o, y_o  operands after one iteration
//   y_zero_o  y_i is zero: the loop is finished and x_i holds the odd gcd
// One iteration: halve y if even; otherwise subtract the smaller operand
// from the larger, keeping the smaller one in x.
module gcd_binary_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] x_o,
  output logic [WIDTH-1:0] y_o,
  output logic             y_zero_o
);

  // A single subtractor serves both the compare and the difference:
  // the borrow of y-x says x>y, and in that case x-y is just -(y-x).
  logic [WIDTH:0]   diff;
  logic             y_zero;

  assign diff     = {1'b0, y_i} - {1'b0, x_i};
  assign y_zero   = (y_i == '0);
  assign y_zero_o = y_zero;

  always_comb begin
    x_o = x_i;
    y_o = y_i;
    if (!y_zero) begin
      if (!y_i[0]) begin
        y_o = y_i >> 1;
      end else if (diff[WIDTH]) begin
        // x > y: swap-subtract so x keeps the smaller (odd) value
        x_o = y_i;
        y_o = -diff[WIDTH-1:0];
      end else begin
        y_o = diff[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/gcd_binary.sv
// gcd_binary
// Iterative binary (Stein) GCD coprocessor with a start/done handshake.
// Uses shifts and subtractions only; latency is O(WIDTH) regardless of the
// operand ratio. Zero operands are handled: gcd(0,b)=b, gcd(a,0)=a,
// gcd(0,0)=0, and zero_in flags these cases.
//   clock  sole clock, rising edge
//   reset  asynchronous, active-high
//   bus    gcd_binary_if slave port (start, a, b, outp, done, busy, zero_in)
module gcd_binary
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  gcd_binary_if.slave bus
);

  // Counter for the common power of two; never exceeds WIDTH-1.
  localparam int KW = $clog2(WIDTH) + 1;

  state_e           state_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] outp_q;
  logic             done_q;
  logic             busy_q;
  logic             zero_in_q;

  logic [WIDTH-1:0] x_d;
  logic [WIDTH-1:0] y_d;
  logic             y_zero;

  gcd_binary_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .x_i      (x_q),
    .y_i      (y_q),
    .x_o      (x_d),
    .y_o      (y_d),
    .y_zero_o (y_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      k_q       <= '0;
      outp_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      zero_in_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            x_q     <= bus.a;
            y_q     <= bus.b;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= CHECK;
          end
        end

        CHECK: begin
          if (x_q == '0 || y_q == '0) begin
            // One (or both) operands zero: the other one is the answer.
            outp_q    <= x_q | y_q;
            zero_in_q <= 1'b1;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= DONE;
          end else begin
            state_q <= STRIP;
          end
        end

        STRIP: begin
          // Remove the common power of two, remembering it in k.
          if (!x_q[0] && !y_q[0]) begin
            x_q <= x_q >> 1;
            y_q <= y_q >> 1;
            k_q <= k_q + KW'(1);
          end else begin
            state_q <= ODDX;
          end
        end

        ODDX: begin
          // Remaining factors of two in x alone cannot be in the gcd.
          if (!x_q[0]) begin
            x_q <= x_q >> 1;
          end else begin
            state_q <= LOOP;
          end
        end

        LOOP: begin
          if (y_zero) begin
            // Result never exceeds min(a,b), so the shift cannot overflow.
            outp_q    <= x_q << k_q;
            zero_in_q <= 1'b0;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= DONE;
          end else begin
            x_q <= x_d;
            y_q <= y_d;
          end
        end

        DONE: begin
          // start is deliberately not looked at here.
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.outp    = outp_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.zero_in = zero_in_q;

endmodule

// File: tb/tb_gcd_binary.sv
// tb_gcd_binary
// Self-checking bench for gcd_binary: directed cases, randomized operands
// against a Euclid reference, start-while-busy, async reset abort, and a
// 32-bit instance. One line per transaction.
module tb_gcd_binary;
  import gcd_pkg::*;

  logic clock;
  logic reset;

  gcd_binary_if #(.WIDTH(8))  bus8 ();
  gcd_binary_if #(.WIDTH(32)) bus32 ();

  gcd_binary #(.WIDTH(8)) dut8 (
    .clock (clock),
    .reset (reset),
    .bus   (bus8)
  );

  gcd_binary #(.WIDTH(32)) dut32 (
    .clock (clock),
    .reset (reset),
    .bus   (bus32)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: Euclid's algorithm with the remainder operator.
  function automatic longint unsigned ref_gcd(input longint unsigned a, input longint unsigned b);
    longint unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Issue one request on the 8-bit instance from an idle engine.
  // Called and returns at posedge+1; lat counts cycles from the start
  // cycle to the done cycle; returns one cycle after done.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                      output int lat, output int bcnt,
                      output logic [7:0] res, output logic zin,
                      output logic ovl, output logic held);
    bus8.a     = av;
    bus8.b     = bv;
    bus8.start = 1'b1;
    @(posedge clock); #1;
    bus8.start = 1'b0;
    lat  = 1;
    bcnt = 0;
    while (bus8.done !== 1'b1 && lat < 200) begin
      if (bus8.busy === 1'b1) bcnt++;
      @(posedge clock); #1;
      lat++;
    end
    ovl = bus8.busy;
    res = bus8.outp;
    zin = bus8.zero_in;
    @(posedge clock); #1;
    held = (bus8.outp === res) && (bus8.zero_in === zin) && (bus8.done === 1'b0);
  endtask

  task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input int exp_lat);
    int         lat, bcnt;
    logic [7:0] res;
    logic       zin, ovl, held;
    run8(av, bv, lat, bcnt, res, zin, ovl, held);
    $display("op %s a=%0d b=%0d -> outp=%0d zero_in=%0d lat=%0d", tag, av, bv, res, zin, lat);
    check({tag, " outp"},    64'(res), ref_gcd(64'(av), 64'(bv)));
    check({tag, " zero_in"}, 64'(zin), 64'(av == 0 || bv == 0));
    check({tag, " bound"},   64'(lat <= int'(gcd_lat_bound(8))), 64'd1);
    check({tag, " busy_len"}, 64'(bcnt), 64'(lat - 1));
    check({tag, " no_overlap"}, 64'(ovl), 64'd0);
    check({tag, " held"},    64'(held), 64'd1);
    if (exp_lat >= 0) check({tag, " latency"}, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    logic [7:0] ra, rb;
    int         cyc, ndone;
    logic [7:0] spam_res;

    reset       = 1'b1;
    bus8.start  = 1'b0;
    bus8.a      = '0;
    bus8.b      = '0;
    bus32.start = 1'b0;
    bus32.a     = '0;
    bus32.b     = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset outp",    64'(bus8.outp), 64'd0);
    check("reset done",    64'(bus8.done), 64'd0);
    check("reset busy",    64'(bus8.busy), 64'd0);
    check("reset zero_in", 64'(bus8.zero_in), 64'd0);
    check("reset state",   64'(dut8.state_q), 64'(IDLE));
    reset = 1'b0;

    // Directed cases; the start is in the first cycle after release.
    // 48,18: check, 2 strip, 4 oddx, 4 loop, done -> done in cycle 12.
    op8("48_18", 8'd48, 8'd18, 12);
    op8("0_37",  8'd0,  8'd37, 2);
    op8("0_0",   8'd0,  8'd0,  2);
    op8("37_0",  8'd37, 8'd0,  2);
    op8("255_1", 8'd255, 8'd1, -1);
    op8("128_64", 8'd128, 8'd64, 13);
    op8("255_255", 8'd255, 8'd255, -1);

    // Randomized operands, with zeros and shared powers of two mixed in.
    for (int i = 0; i < 1500; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      case ($urandom_range(0, 7))
        0: ra = 8'd0;
        1: rb = 8'd0;
        2: begin
          ra = 8'(($urandom_range(1, 15)) << $urandom_range(0, 4));
          rb = 8'(($urandom_range(1, 15)) << $urandom_range(0, 4));
        end
        default: ;
      endcase
      op8("rand", ra, rb, -1);
    end

    // start held high through the whole run with changing operands:
    // only the first request counts, including a start in the DONE cycle.
    bus8.a     = 8'd48;
    bus8.b     = 8'd18;
    bus8.start = 1'b1;
    ndone      = 0;
    cyc        = 0;
    spam_res   = '0;
    while (ndone == 0 && cyc < 100) begin
      @(posedge clock); #1;
      cyc++;
      bus8.a = 8'($urandom);
      bus8.b = 8'($urandom);
      if (bus8.done === 1'b1) begin
        ndone++;
        spam_res = bus8.outp;
      end
    end
    @(posedge clock); #1;
    bus8.start = 1'b0;
    check("spam busy_after_done", 64'(bus8.busy), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      if (bus8.done === 1'b1) ndone++;
    end
    $display("op spam a=48 b=18 -> outp=%0d dones=%0d", spam_res, ndone);
    check("spam outp",  64'(spam_res), 64'd6);
    check("spam dones", 64'(ndone), 64'd1);

    // Asynchronous reset in the middle of the reduction loop.
    bus8.a     = 8'd255;
    bus8.b     = 8'd1;
    bus8.start = 1'b1;
    @(posedge clock); #1;
    bus8.start = 1'b0;
    cyc = 0;
    while (dut8.state_q != LOOP && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("abort reached_loop", 64'(dut8.state_q == LOOP), 64'd1);
    @(posedge clock); #1;
    check("abort busy_before", 64'(bus8.busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    $display("op abort-reset -> outp=%0d busy=%0d state=%0d", bus8.outp, bus8.busy, dut8.state_q);
    check("abort outp",    64'(bus8.outp), 64'd0);
    check("abort busy",    64'(bus8.busy), 64'd0);
    check("abort done",    64'(bus8.done), 64'd0);
    check("abort zero_in", 64'(bus8.zero_in), 64'd0);
    check("abort state",   64'(dut8.state_q), 64'(IDLE));
    @(negedge clock);
    reset = 1'b0;
    op8("12_8", 8'd12, 8'd8, 11);

    // 32-bit instance: gcd(2^31, 3*2^20) = 2^20.
    bus32.a     = 32'h8000_0000;
    bus32.b     = 32'd3 << 20;
    bus32.start = 1'b1;
    @(posedge clock); #1;
    bus32.start = 1'b0;
    cyc = 1;
    while (bus32.done !== 1'b1 && cyc < 300) begin
      @(posedge clock); #1;
      cyc++;
    end
    $display("op w32 a=%0d b=%0d -> outp=%0d lat=%0d", 32'h8000_0000, 32'd3 << 20, bus32.outp, cyc);
    check("w32 outp",    64'(bus32.outp), 64'd1 << 20);
    check("w32 zero_in", 64'(bus32.zero_in), 64'd0);
    check("w32 bound",   64'(cyc <= int'(gcd_lat_bound(32))), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
